tag_stream_unpacker: RTL

// - Receiving end of the time-tag AXI stream: slave side, consumes WORD_WIDTH-wide beats (tkeep-masked tags)
// - Serialises them to one tag per cycle; decodes signed channel into channel index + edge polarity.
// - Sits between the FPGA-link tag source and per-channel measurement blocks (counters, histograms).

---
 rtl/tag_stream_unpacker.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/tag_stream_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : tag_stream_unpacker
// Purpose  : Receiving end of the time-tag AXI stream. Accepts WORD_WIDTH-slot
//            beats (tkeep-masked tags) and serialises them to one decoded tag
//            per cycle for per-channel measurement blocks. The signed channel
//            field is split into a zero-based index and an edge polarity.
//            Slots whose channel is 0 are dropped and counted.
// Ports    : clk, rst_n (async, active low)
//            s_tvalid/s_tready/s_tkeep/s_tagtime/s_channel/s_lowest_time_bound
//                 - input beat stream
//            m_tvalid/m_tready/m_tagtime/m_channel_idx/m_rising
//                 - decoded tag stream, registered outputs
//            m_lowest_time_bound - monotonic bound valid for all future m_ tags
//            invalid_cnt         - saturating count of channel==0 tags dropped
// Options  : TAG_ORDER_CHECK_EN adds order_err (sticky) and order_err_cnt
//            (saturating) that flag tags emitted out of time order.
// Revision : 1.0 - initial release
// ============================================================================
module tag_stream_unpacker #(
    parameter int WORD_WIDTH    = 4,
    parameter int TIME_WIDTH    = 64,
    parameter int CHANNEL_WIDTH = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                s_tvalid,
    output logic                                s_tready,
    input  logic [WORD_WIDTH-1:0]               s_tkeep,
    input  logic [WORD_WIDTH*TIME_WIDTH-1:0]    s_tagtime,
    input  logic [WORD_WIDTH*CHANNEL_WIDTH-1:0] s_channel,
    input  logic [TIME_WIDTH-1:0]               s_lowest_time_bound,
    output logic                                m_tvalid,
    input  logic                                m_tready,
    output logic [TIME_WIDTH-1:0]               m_tagtime,
    output logic [CHANNEL_WIDTH-2:0]            m_channel_idx,
    output logic                                m_rising,
    output logic [TIME_WIDTH-1:0]               m_lowest_time_bound,
    output logic [15:0]                         invalid_cnt
`ifdef TAG_ORDER_CHECK_EN
    ,
    output logic                                order_err,
    output logic [15:0]                         order_err_cnt
`endif
);

    localparam int c_CNT_W = $clog2(WORD_WIDTH + 1);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t                             r_state;
    logic                               r_ready_en;
    // Remaining mask: valid-channel slots of the held beat not yet handshaken,
    // including the slot currently presented on m_.
    logic [WORD_WIDTH-1:0]              r_rem;
    logic [WORD_WIDTH*TIME_WIDTH-1:0]   r_time;
    logic [WORD_WIDTH*CHANNEL_WIDTH-1:0] r_chan;
    logic [TIME_WIDTH-1:0]              r_bound_pending;

    logic                               w_hs;
    logic [WORD_WIDTH-1:0]              w_rem_after;
    logic                               w_accept;
    logic [WORD_WIDTH-1:0]              w_in_mask;
    logic [c_CNT_W-1:0]                 w_inv_n;
    logic [16:0]                        w_inv_sum;
    logic [WORD_WIDTH-1:0]              w_src_mask;
    logic [WORD_WIDTH*TIME_WIDTH-1:0]   w_src_time;
    logic [WORD_WIDTH*CHANNEL_WIDTH-1:0] w_src_chan;
    logic [TIME_WIDTH-1:0]              w_sel_time;
    logic [CHANNEL_WIDTH-1:0]           w_sel_chan;
    logic [CHANNEL_WIDTH-1:0]           w_chan_m1;
    logic                               w_sel_rising;
    logic [CHANNEL_WIDTH-2:0]           w_sel_idx;
    logic                               w_last_hs;
    logic                               w_empty_accept;
    logic [TIME_WIDTH-1:0]              w_bound_next;

    assign m_tvalid    = (r_state == ST_DRAIN);
    assign w_hs        = m_tvalid & m_tready;
    // Clearing the lowest set bit retires the tag currently on m_.
    assign w_rem_after = w_hs ? (r_rem & (r_rem - WORD_WIDTH'(1))) : r_rem;
    // Ready when nothing will remain after this cycle, so a new beat can be
    // taken in the same cycle the last tag leaves (no bubble).
    assign s_tready    = r_ready_en & (w_rem_after == '0);
    assign w_accept    = s_tvalid & s_tready;

    // Channel==0 slots are stripped from the mask as the beat is taken, so the
    // remaining mask only ever holds tags that will really be emitted.
    always_comb begin
        w_in_mask = '0;
        w_inv_n   = '0;
        for (int m = 0; m < WORD_WIDTH; m++) begin
            if (s_tkeep[m]) begin
                if (s_channel[m*CHANNEL_WIDTH +: CHANNEL_WIDTH] != '0) begin
                    w_in_mask[m] = 1'b1;
                end else begin
                    w_inv_n = w_inv_n + c_CNT_W'(1);
                end
            end
        end
    end

    assign w_inv_sum  = {1'b0, invalid_cnt} + 17'(w_inv_n);

    // Next tag comes from the incoming beat when one is accepted, otherwise
    // from the held beat.
    assign w_src_mask = w_accept ? w_in_mask : w_rem_after;
    assign w_src_time = w_accept ? s_tagtime : r_time;
    assign w_src_chan = w_accept ? s_channel : r_chan;

    // Descending scan: the last hit is the lowest set slot.
    always_comb begin
        w_sel_time = '0;
        w_sel_chan = '0;
        for (int m = WORD_WIDTH - 1; m >= 0; m--) begin
            if (w_src_mask[m]) begin
                w_sel_time = w_src_time[m*TIME_WIDTH +: TIME_WIDTH];
                w_sel_chan = w_src_chan[m*CHANNEL_WIDTH +: CHANNEL_WIDTH];
            end
        end
    end

    // +(k+1) is rising edge k, -(k+1) is falling edge k; ~ch == -ch-1.
    assign w_sel_rising = ~w_sel_chan[CHANNEL_WIDTH-1];
    assign w_chan_m1    = w_sel_chan - CHANNEL_WIDTH'(1);
    assign w_sel_idx    = w_sel_rising ? w_chan_m1[CHANNEL_WIDTH-2:0]
                                       : ~w_sel_chan[CHANNEL_WIDTH-2:0];

    assign w_last_hs      = w_hs & (w_rem_after == '0);
    assign w_empty_accept = w_accept & (w_in_mask == '0);

    // The bound only ever moves upward.
    always_comb begin
        w_bound_next = m_lowest_time_bound;
        if (w_last_hs && (r_bound_pending > w_bound_next)) begin
            w_bound_next = r_bound_pending;
        end
        if (w_empty_accept && (s_lowest_time_bound > w_bound_next)) begin
            w_bound_next = s_lowest_time_bound;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state             <= ST_EMPTY;
            r_ready_en          <= 1'b0;
            r_rem               <= '0;
            r_time              <= '0;
            r_chan              <= '0;
            r_bound_pending     <= '0;
            m_tagtime           <= '0;
            m_channel_idx       <= '0;
            m_rising            <= 1'b0;
            m_lowest_time_bound <= '0;
            invalid_cnt         <= '0;
        end else begin
            r_ready_en          <= 1'b1;
            m_lowest_time_bound <= w_bound_next;
            if (w_accept) begin
                r_time          <= s_tagtime;
                r_chan          <= s_channel;
                r_bound_pending <= s_lowest_time_bound;
                invalid_cnt     <= w_inv_sum[16] ? 16'hFFFF : w_inv_sum[15:0];
            end
            if (w_accept || w_hs) begin
                r_rem   <= w_src_mask;
                r_state <= (w_src_mask != '0) ? ST_DRAIN : ST_EMPTY;
                if (w_src_mask != '0) begin
                    m_tagtime     <= w_sel_time;
                    m_channel_idx <= w_sel_idx;
                    m_rising      <= w_sel_rising;
                end
            end
        end
    end

`ifdef TAG_ORDER_CHECK_EN
    logic [TIME_WIDTH-1:0] r_prev_time;
    logic                  r_have_prev;
    logic                  w_order_bad;

    // Checked on the emitting handshake; the tag itself is forwarded as is.
    assign w_order_bad = w_hs & ((r_have_prev & (m_tagtime < r_prev_time)) |
                                 (m_tagtime < m_lowest_time_bound));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_time   <= '0;
            r_have_prev   <= 1'b0;
            order_err     <= 1'b0;
            order_err_cnt <= '0;
        end else begin
            if (w_hs) begin
                r_prev_time <= m_tagtime;
                r_have_prev <= 1'b1;
            end
            if (w_order_bad) begin
                order_err <= 1'b1;
                if (order_err_cnt != 16'hFFFF) begin
                    order_err_cnt <= order_err_cnt + 16'd1;
                end
            end
        end
    end
`else
    // Order checking not built: no extra ports or comparators.
`endif

endmodule
`default_nettype wire
